// File: rtl/lsu_multicycle.sv
// ============================================================================
// Module   : lsu_multicycle
// Brief    : Load/store unit that drives a multi-cycle req/ack memory with
//            lane-aligned byte enables, store data and extended load data.
//            Optional watchdog abort: define LSU_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_multicycle #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                is_store,
    input  logic [1:0]          size,
    input  logic                sign_ext,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    output logic                busy,
    output logic                done,
    output logic [DATA_W-1:0]   rdata,
    output logic                misalign,
    output logic                timeout,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ack
);

    localparam int BE_W   = DATA_W / 8;
    localparam int LANE_W = $clog2(BE_W);

    if ((DATA_W != 32 && DATA_W != 64) || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("lsu_multicycle: unsupported DATA_W or TIMEOUT_CYCLES");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        FINISH = 2'd2
    } state_t;

    // Right-justified byte enables covering 2^s bytes
    function automatic logic [BE_W-1:0] size_be(input logic [1:0] s);
        logic [7:0] b;
        case (s)
            2'd0:    b = 8'h01;
            2'd1:    b = 8'h03;
            2'd2:    b = 8'h0F;
            default: b = 8'hFF;
        endcase
        return b[BE_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] be_to_mask(input logic [BE_W-1:0] be);
        logic [DATA_W-1:0] m;
        for (int i = 0; i < BE_W; i++) begin
            m[8*i +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

    state_t              state_q,     state_d;
    logic                store_q,     store_d;
    logic [1:0]          size_q,      size_d;
    logic                sext_q,      sext_d;
    logic [LANE_W-1:0]   lane_q,      lane_d;
    logic                mis_q,       mis_d;
    logic [DATA_W-1:0]   rdata_q,     rdata_d;
    logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
    logic [BE_W-1:0]     mem_be_q,    mem_be_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]    cnt_q,       cnt_d;
    logic                to_q,        to_d;
`endif

    logic [LANE_W-1:0]   w_lane;
    logic [2:0]          w_align_mask;
    logic                w_misalign;
    logic [BE_W-1:0]     w_acc_be;
    logic [DATA_W-1:0]   w_shifted;
    logic [DATA_W-1:0]   w_ld_mask;
    logic                w_top;
    logic [DATA_W-1:0]   w_load;

    always_comb begin
        w_lane       = addr[LANE_W-1:0];
        w_align_mask = 3'((4'd1 << size) - 4'd1);
        w_misalign   = ((size == 2'd3) && (DATA_W != 64)) ||
                       ((addr[2:0] & w_align_mask) != 3'd0);
        w_acc_be     = size_be(size);

        w_shifted = mem_rdata >> {lane_q, 3'b000};
        w_ld_mask = be_to_mask(size_be(size_q));
        case (size_q)
            2'd0:    w_top = w_shifted[7];
            2'd1:    w_top = w_shifted[15];
            2'd2:    w_top = w_shifted[31];
            default: w_top = w_shifted[DATA_W-1];
        endcase
        // A full-width mask leaves no bits to extend into, so sign_ext drops out
        w_load = (w_shifted & w_ld_mask) | ({DATA_W{sext_q & w_top}} & ~w_ld_mask);
    end

    always_comb begin
        state_d     = state_q;
        store_d     = store_q;
        size_d      = size_q;
        sext_d      = sext_q;
        lane_d      = lane_q;
        mis_d       = mis_q;
        rdata_d     = rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
`ifdef LSU_TIMEOUT_EN
        cnt_d       = cnt_q;
        to_d        = to_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    store_d = is_store;
                    size_d  = size;
                    sext_d  = sign_ext;
                    lane_d  = w_lane;
                    mis_d   = w_misalign;
`ifdef LSU_TIMEOUT_EN
                    cnt_d   = '0;
                    to_d    = 1'b0;
`endif
                    if (w_misalign) begin
                        state_d = FINISH;
                    end else begin
                        state_d     = ACCESS;
                        mem_addr_d  = {addr[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
                        mem_be_d    = w_acc_be << w_lane;
                        mem_wdata_d = (wdata & be_to_mask(w_acc_be)) << {w_lane, 3'b000};
                    end
                end
            end
            ACCESS: begin
                if (mem_ack) begin
                    state_d = FINISH;
                    if (!store_q) begin
                        rdata_d = w_load;
                    end
                end
`ifdef LSU_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = FINISH;
                    to_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            store_q     <= 1'b0;
            size_q      <= 2'd0;
            sext_q      <= 1'b0;
            lane_q      <= '0;
            mis_q       <= 1'b0;
            rdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
`ifdef LSU_TIMEOUT_EN
            cnt_q       <= '0;
            to_q        <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            store_q     <= store_d;
            size_q      <= size_d;
            sext_q      <= sext_d;
            lane_q      <= lane_d;
            mis_q       <= mis_d;
            rdata_q     <= rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
`ifdef LSU_TIMEOUT_EN
            cnt_q       <= cnt_d;
            to_q        <= to_d;
`endif
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == FINISH);
    assign mem_req   = (state_q == ACCESS);
    assign mem_we    = mem_req & store_q;
    assign misalign  = done & mis_q;
`ifdef LSU_TIMEOUT_EN
    assign timeout   = done & to_q;
`else
    assign timeout   = 1'b0;
`endif
    assign rdata     = rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;

endmodule

`default_nettype wire

// File: doc/lsu_multicycle.md
Name: lsu_multicycle

Overview:
Parametrised load/store unit that replaces the combinational data-memory path of the single-cycle datapath.
- Accepts one byte/half/word/dword access per request and drives a multi-cycle memory over a req/ack handshake.
- Generates byte enables and lane-aligned store data; extracts, sign- or zero-extends load data.
- Flags misaligned or illegal accesses without touching memory.
- Sits between the ALU address result and the register-file write-back mux.

Parameters:
DATA_W, 32, datapath and memory word width; legal values 32 or 64.
ADDR_W, 32, byte-address width.
TIMEOUT_CYCLES, 255, cycles to wait for mem_ack before abort; used only with LSU_TIMEOUT_EN.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  request strobe; accepted only when busy=0
is_store  in  1  1=store, 0=load; sampled with start
size  in  2  log2 access bytes: 0 byte, 1 half, 2 word, 3 dword (dword legal only if DATA_W=64)
sign_ext  in  1  1=sign-extend load, 0=zero-extend; sampled with start
addr  in  ADDR_W  byte address; sampled with start
wdata  in  DATA_W  store data, right-justified; sampled with start
busy  out  1  high from cycle after accepted start until done
done  out  1  one-cycle completion pulse
rdata  out  DATA_W  extended load result; valid with done, held until next done
misalign  out  1  valid with done; access aborted for alignment/illegal size
timeout  out  1  valid with done; access aborted by watchdog (0 without macro)
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  write enable, stable while mem_req
mem_addr  out  ADDR_W  word-aligned address (low log2(DATA_W/8) bits zero)
mem_be  out  DATA_W/8  byte enables; little-endian, lane = addr low bits
mem_wdata  out  DATA_W  store data shifted into lane position
mem_rdata  in  DATA_W  read data, valid when mem_ack=1
mem_ack  in  1  access complete; sampled only while mem_req=1

Behaviour:
- Reset (async, any state): state IDLE. busy, done, misalign, timeout, mem_req, mem_we = 0. mem_addr, mem_be, mem_wdata, rdata = 0.
- FSM states: IDLE, ACCESS, FINISH.
- IDLE:
  - start=1: latch is_store, size, sign_ext, addr, wdata; busy=1 next cycle.
  - Aligned, legal access: go to ACCESS; mem_req=1 on the next edge.
  - Misaligned (addr mod 2^size != 0) or illegal size: go to FINISH with misalign=1; mem_req never asserted.
- ACCESS:
  - mem_req=1; mem_addr, mem_we, mem_be, mem_wdata are constant.
  - mem_ack=1: load captures the extracted and extended lane into rdata; go to FINISH.
  - mem_ack held low: wait indefinitely (unless the optional feature is compiled in).
- FINISH: done=1 for exactly one cycle; busy=0 and mem_req=0 from the next edge; return to IDLE.
- start while busy=1 is ignored; no queueing.
- Latency: start accepted at edge N; mem_req high after N+1; mem_ack seen at edge M; done high after M+1. Best case is done two cycles after start (ack in the first ACCESS cycle). Misaligned access: done one cycle after start.
- Lane math:
  - lane = addr[log2(DATA_W/8)-1:0].
  - mem_be = ((1<<2^size)-1) << lane.
  - mem_wdata = wdata << (8*lane), with unused bytes zero.
- Load data: extracted bytes are mem_rdata >> (8*lane), truncated to 2^size bytes.
  - Sign extension replicates the top extracted bit to DATA_W.
  - A full-width access ignores sign_ext.
- Store: rdata keeps its previous value; done, misalign=0.
- misalign and timeout are valid only in the done cycle and are 0 otherwise.
- mem_ack outside ACCESS is ignored.

Optional Feature:
LSU_TIMEOUT_EN
- Defined: a cycle counter clears on entry to ACCESS and increments each ACCESS cycle.
  - When it reaches TIMEOUT_CYCLES with no mem_ack, drop mem_req and go to FINISH with timeout=1; rdata is unchanged.
  - mem_ack in the same cycle as expiry wins; the access completes normally.
- Undefined: no counter logic; timeout is tied to 0 and ACCESS waits forever.

Test Plan:
- Store byte: DATA_W=32, addr=0x103, size=0, wdata=0xAB, ack after 3 cycles -> mem_addr=0x100, mem_be=4'b1000, mem_wdata=0xAB000000, mem_we=1; done exactly 1 cycle after ack; misalign=0.
- Signed half load: addr=0x202, size=1, sign_ext=1, mem_rdata=0x80F01234 -> rdata=0xFFFF80F0. Same access with sign_ext=0 -> rdata=0x000080F0.
- Misaligned word: addr=0x302, size=2 -> mem_req never high; done one cycle after start with misalign=1. size=3 with DATA_W=32 -> misalign=1.
- Back-to-back: start re-asserted while busy -> ignored. Start on the cycle after done -> accepted, zero-idle second access completes correctly.
- Reset mid-access: rst asserted while mem_req=1 -> mem_req, busy, done drop immediately without a clock edge. After release, next start behaves as from power-up.
- LSU_TIMEOUT_EN with TIMEOUT_CYCLES=4, no ack -> mem_req drops after 4 ACCESS cycles; done with timeout=1; rdata unchanged. DATA_W=64 dword load at addr=0x8 -> mem_be=8'hFF.
